// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master sequencer
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD
  } spi_state_e;

  localparam int   SPI_BYTE_W = 8;
  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;

  // Width able to hold n_values distinct counts; never narrower than one bit.
  function automatic int spi_cnt_w(input int n_values);
    return (n_values > 1) ? $clog2(n_values) : 1;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host stream, receive, pad and PISO signals of the SPI master
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  sclk;
  logic                  cs_n;
  logic                  miso;
  logic [SPI_BYTE_W-1:0] piso_data;
  logic                  piso_load;
  logic                  piso_shift;

  modport master (
    input  tx_data, tx_valid, tx_last, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, cs_n,
           piso_data, piso_load, piso_shift
  );

  modport slave (
    output tx_data, tx_valid, tx_last, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, cs_n,
           piso_data, piso_load, piso_shift
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with rise/fall phase ticks, held idle while disabled
module spi_sclk_gen import spi_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int             DIV_W   = spi_cnt_w(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(2 * CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Ticks describe the edge about to happen, so callers act in the same cycle.
  assign rise_tick = en && (div_cnt == RISE_AT);
  assign fall_tick = en && (div_cnt == FALL_AT);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      sclk    <= SPI_CPOL;
    end else begin
      if (fall_tick) begin
        div_cnt <= '0;
        sclk    <= SPI_CPOL;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
        if (rise_tick) begin
          sclk <= ~SPI_CPOL;
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode 0 byte sequencer driving a PISO, with CS_n framing and MISO capture
module spi_master_ctrl import spi_pkg::*; #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic clk,
  input  logic rst,
  spi_master_ctrl_if.master bus
);

  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WAIT_W   = spi_cnt_w(WAIT_MAX);
  localparam int BIT_W    = spi_cnt_w(SPI_BYTE_W);

  localparam logic [WAIT_W-1:0] SETUP_END = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_END  = WAIT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SPI_BYTE_W - 1);

  spi_state_e            state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  last_q;
  logic [SPI_BYTE_W-1:0] rx_sr;
  logic [SPI_BYTE_W-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  cs_n_q;

  logic tx_ready;
  logic accept;
  logic shift_en;
  logic sclk;
  logic rise_tick;
  logic fall_tick;

  assign tx_ready = (state == ST_IDLE) || (state == ST_NEXT);
  assign accept   = bus.tx_valid && tx_ready;
  assign shift_en = (state == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (shift_en),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // The PISO already presents bit 7 after load, so only 7 shifts are needed per byte.
  assign bus.piso_load  = accept;
  assign bus.piso_data  = accept ? bus.tx_data : '0;
  assign bus.piso_shift = fall_tick && (bit_cnt != LAST_BIT);

  assign bus.tx_ready = tx_ready;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.sclk     = sclk;
  assign bus.cs_n     = cs_n_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      bit_cnt    <= '0;
      last_q     <= 1'b0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_q   <= bus.tx_last;
            cs_n_q   <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (wait_cnt == SETUP_END) begin
            wait_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (rise_tick) begin
            rx_sr <= {rx_sr[SPI_BYTE_W-2:0], bus.miso};
          end
          // Bit 7 was captured on its rising edge, so rx_sr is complete here.
          if (fall_tick) begin
            if (bit_cnt == LAST_BIT) begin
              rx_data_q  <= rx_sr;
              rx_valid_q <= 1'b1;
              bit_cnt    <= '0;
              wait_cnt   <= '0;
              state      <= last_q ? ST_HOLD : ST_NEXT;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        ST_NEXT: begin
          if (accept) begin
            last_q <= bus.tx_last;
            state  <= ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (wait_cnt == HOLD_END) begin
            wait_cnt <= '0;
            cs_n_q   <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          cs_n_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed checks of spi_master_ctrl with PISO and slave models
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if if0 ();
  spi_master_ctrl_if if1 ();

  spi_master_ctrl #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  spi_master_ctrl #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  logic [7:0] drv_data  = 8'h00;
  logic       drv_last  = 1'b0;
  logic       drv_valid = 1'b0;
  logic       sel       = 1'b0;
  logic       pat_mode  = 1'b0;
  logic [7:0] pat       = 8'h3C;

  assign if0.tx_data  = drv_data;
  assign if0.tx_last  = drv_last;
  assign if0.tx_valid = drv_valid & ~sel;
  assign if1.tx_data  = drv_data;
  assign if1.tx_last  = drv_last;
  assign if1.tx_valid = drv_valid & sel;

  logic [7:0] piso0, piso1;
  always @(posedge clk) begin
    if (rst) piso0 <= 8'h00;
    else if (if0.piso_load) piso0 <= if0.piso_data;
    else if (if0.piso_shift) piso0 <= {piso0[6:0], 1'b0};
  end
  always @(posedge clk) begin
    if (rst) piso1 <= 8'h00;
    else if (if1.piso_load) piso1 <= if1.piso_data;
    else if (if1.piso_shift) piso1 <= {piso1[6:0], 1'b0};
  end

  // Slave model: presents pat MSB first, advancing after each SCLK fall.
  logic [2:0] sbit = 3'd0;
  logic       s_prev_sclk = 1'b0;
  logic       pat_bit;
  assign pat_bit = pat[3'd7 - sbit];
  always @(negedge clk) begin
    if (if0.cs_n) sbit = 3'd0;
    else if (s_prev_sclk && !if0.sclk) sbit = sbit + 3'd1;
    s_prev_sclk = if0.sclk;
  end

  assign if0.miso = pat_mode ? pat_bit : piso0[7];
  assign if1.miso = piso1[7];

  logic       m_ready, m_busy, m_sclk, m_cs, m_load, m_shift, m_rxv, m_mosi;
  logic [7:0] m_rxd;
  assign m_ready = sel ? if1.tx_ready   : if0.tx_ready;
  assign m_busy  = sel ? if1.busy       : if0.busy;
  assign m_sclk  = sel ? if1.sclk       : if0.sclk;
  assign m_cs    = sel ? if1.cs_n       : if0.cs_n;
  assign m_load  = sel ? if1.piso_load  : if0.piso_load;
  assign m_shift = sel ? if1.piso_shift : if0.piso_shift;
  assign m_rxv   = sel ? if1.rx_valid   : if0.rx_valid;
  assign m_rxd   = sel ? if1.rx_data    : if0.rx_data;
  assign m_mosi  = sel ? piso1[7]       : piso0[7];

  int n_load, n_shift, n_rise, n_cs_low, n_cs_rise, n_sclk_hi, cyc, rise1, rise2;
  logic [7:0] mosi_acc, load_data;
  logic [7:0] rx_log[$];
  logic prev_sclk = 1'b0;
  logic prev_cs   = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (m_load) begin n_load++; load_data = sel ? if1.piso_data : if0.piso_data; end
    if (m_shift) n_shift++;
    if (m_rxv) rx_log.push_back(m_rxd);
    if (m_sclk && !prev_sclk) begin
      if (n_rise == 0) rise1 = cyc;
      else if (n_rise == 1) rise2 = cyc;
      n_rise++;
      mosi_acc = {mosi_acc[6:0], m_mosi};
    end
    if (m_sclk) n_sclk_hi++;
    if (!m_cs) n_cs_low++;
    if (m_cs && !prev_cs) n_cs_rise++;
    prev_sclk = m_sclk;
    prev_cs   = m_cs;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_load = 0; n_shift = 0; n_rise = 0; n_cs_low = 0; n_cs_rise = 0;
    n_sclk_hi = 0; rise1 = 0; rise2 = 0; mosi_acc = 8'h00; load_data = 8'h00;
    rx_log.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    @(posedge clk); #1;
    drv_data = d; drv_last = last; drv_valid = 1'b1;
    while (!m_ready && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) chk("accept_timeout", 32'(n), 0);
    @(posedge clk); #1;
    drv_valid = 1'b0; drv_last = 1'b0; drv_data = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (m_busy && n < 5000);
    if (n >= 5000) chk("idle_timeout", 32'(n), 0);
    @(negedge clk); #1;
  endtask

  initial begin
    int n;
    logic bad;
    clear_mon();

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", if0.cs_n, 1);
    chk("rst_sclk", if0.sclk, 0);
    chk("rst_tx_ready", if0.tx_ready, 1);
    chk("rst_busy", if0.busy, 0);
    chk("rst_rx_valid", if0.rx_valid, 0);
    chk("rst_rx_data", if0.rx_data, 0);
    chk("rst_piso_load", if0.piso_load, 0);
    chk("rst_piso_shift", if0.piso_shift, 0);
    chk("rst_piso_data", if0.piso_data, 0);
    rst = 1'b0;

    // 2: single byte 0xA5 in loopback
    @(posedge clk); #1; clear_mon();
    send(8'hA5, 1'b1);
    wait_idle();
    chk("t2_mosi_bits", mosi_acc, 8'hA5);
    chk("t2_sclk_rises", n_rise, 8);
    chk("t2_loads", n_load, 1);
    chk("t2_load_data", load_data, 8'hA5);
    chk("t2_shifts", n_shift, 7);
    chk("t2_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("t2_rx_data", rx_log[0], 8'hA5);
    chk("t2_cs_low_cycles", n_cs_low, 36);

    // 3: three-byte burst, slave returns 0x3C each byte
    pat_mode = 1'b1;
    @(posedge clk); #1; clear_mon();
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    wait_idle();
    chk("t3_rx_count", rx_log.size(), 3);
    for (int i = 0; i < rx_log.size(); i++) chk($sformatf("t3_rx_%0d", i), rx_log[i], 8'h3C);
    chk("t3_cs_rises", n_cs_rise, 1);
    chk("t3_cs_low_cycles", n_cs_low, 102);
    chk("t3_sclk_rises", n_rise, 24);
    chk("t3_shifts", n_shift, 21);
    chk("t3_last_mosi", mosi_acc, 8'hFF);
    pat_mode = 1'b0;

    // 4: stall 10 cycles in NEXT
    @(posedge clk); #1; clear_mon();
    send(8'h12, 1'b0);
    n = 0;
    while (!m_ready && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) chk("t4_next_timeout", 32'(n), 0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bad = bad | m_sclk | m_cs | !m_ready;
    end
    chk("t4_next_idle_lines", bad, 0);
    send(8'h9C, 1'b1);
    wait_idle();
    chk("t4_rx_count", rx_log.size(), 2);
    if (rx_log.size() > 1) begin
      chk("t4_rx0", rx_log[0], 8'h12);
      chk("t4_rx1", rx_log[1], 8'h9C);
    end
    chk("t4_cs_rises", n_cs_rise, 1);
    chk("t4_cs_low_cycles", n_cs_low, 2 + 32 + 1 + 10 + 1 + 32 + 2);

    // 5: reset after the third SCLK rise, then a clean 0x5A
    @(posedge clk); #1; clear_mon();
    send(8'h77, 1'b1);
    n = 0;
    while (n_rise < 3 && n < 5000) begin @(negedge clk); #1; n++; end
    if (n >= 5000) chk("t5_rise_timeout", 32'(n), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_cs_n", m_cs, 1);
    chk("t5_sclk", m_sclk, 0);
    chk("t5_tx_ready", m_ready, 1);
    chk("t5_busy", m_busy, 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_rx", rx_log.size(), 0);
    clear_mon();
    send(8'h5A, 1'b1);
    wait_idle();
    chk("t5_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("t5_rx_data", rx_log[0], 8'h5A);

    // 6: CLK_DIV=1 instance, 0xC3 loopback
    sel = 1'b1;
    @(posedge clk); #1; clear_mon();
    send(8'hC3, 1'b1);
    wait_idle();
    chk("t6_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("t6_rx_data", rx_log[0], 8'hC3);
    chk("t6_sclk_rises", n_rise, 8);
    chk("t6_sclk_period", 32'(rise2 - rise1), 2);
    chk("t6_sclk_high", n_sclk_hi, 8);
    chk("t6_cs_low_cycles", n_cs_low, 20);
    chk("t6_mosi_bits", mosi_acc, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
